// File: rtl/score_display_sequencer.sv
// Converts a 13-bit binary score to four registered BCD digits by repeated division through a
// shared external divide-by-10 unit, with optional leading-zero blanking flags.
module score_display_sequencer #(
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] Score,
   input  logic        Start,
   input  logic        Clear,
   output logic [12:0] DivIn,
   input  logic [12:0] DivQuot,
   input  logic [3:0]  DivRem,
   output logic [3:0]  Digit0,
   output logic [3:0]  Digit1,
   output logic [3:0]  Digit2,
   output logic [3:0]  Digit3,
   output logic [3:0]  Blank,
   output logic        Busy,
   output logic        Done
);

   typedef enum logic [1:0] {StIdle, StDiv, StCommit} state_e;

   localparam logic [3:0] BlankRst = (BLANK_LEADING != 0) ? 4'b1110 : 4'b0000;

   state_e           state_q, state_d;
   logic [12:0]      work_q, work_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [3:0][3:0]  sh_q, sh_d;
   logic [3:0][3:0]  digit_q, digit_d;
   logic [3:0]       blank_q, blank_d;
   logic             done_q, done_d;
   logic [3:0]       blank_new;

   // Blank flags for the shadow digits about to be committed.
   always_comb begin
      blank_new    = 4'b0000;
      blank_new[3] = (sh_q[3] == 4'd0);
      blank_new[2] = blank_new[3] & (sh_q[2] == 4'd0);
      blank_new[1] = blank_new[2] & (sh_q[1] == 4'd0);
      if (BLANK_LEADING == 0) begin
         blank_new = 4'b0000;
      end
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      digit_d = digit_q;
      blank_d = blank_q;
      done_d  = 1'b0;
      if (Clear) begin
         state_d = StIdle;
         work_d  = '0;
         cnt_d   = '0;
         sh_d    = '0;
         digit_d = '0;
         blank_d = BlankRst;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (Start) begin
                  work_d  = Score;
                  cnt_d   = '0;
                  state_d = StDiv;
               end
            end
            StDiv: begin
               sh_d[cnt_q] = DivRem;
               work_d      = DivQuot;
               cnt_d       = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = StCommit;
               end
            end
            StCommit: begin
               digit_d = sh_q;
               blank_d = blank_new;
               done_d  = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         work_q  <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         digit_q <= '0;
         blank_q <= BlankRst;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         digit_q <= digit_d;
         blank_q <= blank_d;
         done_q  <= done_d;
      end
   end

   assign DivIn  = work_q;
   assign Digit0 = digit_q[0];
   assign Digit1 = digit_q[1];
   assign Digit2 = digit_q[2];
   assign Digit3 = digit_q[3];
   assign Blank  = blank_q;
   assign Busy   = (state_q != StIdle);
   assign Done   = done_q;

endmodule

// File: tb/tb_score_display_sequencer.sv
// Self-checking bench: directed and random conversions compared against a cycle-level
// reference model of the conversion timeline built from plain decimal arithmetic.
module tb_score_display_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [12:0] Score;
   logic        Start;
   logic        Clear;

   logic [12:0] div_in_a, div_quot_a, div_in_b, div_quot_b;
   logic [3:0]  div_rem_a, div_rem_b;
   logic [3:0]  d0_a, d1_a, d2_a, d3_a, blank_a;
   logic [3:0]  d0_b, d1_b, d2_b, d3_b, blank_b;
   logic        busy_a, done_a, busy_b, done_b;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   bit          pend;
   int          k;
   int          acc;
   logic [15:0] exp_dig;
   logic [3:0]  exp_blank;
   logic        exp_done;
   int          done_seen;
   int          pow10[5] = '{1, 10, 100, 1000, 10000};

   always #5 clk = ~clk;

   // Behavioural divide-by-10 units, one per DUT.
   assign div_quot_a = div_in_a / 13'd10;
   assign div_rem_a  = 4'(div_in_a % 13'd10);
   assign div_quot_b = div_in_b / 13'd10;
   assign div_rem_b  = 4'(div_in_b % 13'd10);

   score_display_sequencer #(.BLANK_LEADING(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .Score(Score), .Start(Start), .Clear(Clear),
      .DivIn(div_in_a), .DivQuot(div_quot_a), .DivRem(div_rem_a),
      .Digit0(d0_a), .Digit1(d1_a), .Digit2(d2_a), .Digit3(d3_a),
      .Blank(blank_a), .Busy(busy_a), .Done(done_a)
   );

   score_display_sequencer #(.BLANK_LEADING(0)) u_dut_nb (
      .clk(clk), .rst_n(rst_n), .Score(Score), .Start(Start), .Clear(Clear),
      .DivIn(div_in_b), .DivQuot(div_quot_b), .DivRem(div_rem_b),
      .Digit0(d0_b), .Digit1(d1_b), .Digit2(d2_b), .Digit3(d3_b),
      .Blank(blank_b), .Busy(busy_b), .Done(done_b)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] blank_of(input logic [15:0] d);
      logic [3:0] b;
      b    = 4'b0000;
      b[3] = (d[15:12] == 4'd0);
      b[2] = b[3] && (d[11:8] == 4'd0);
      b[1] = b[2] && (d[7:4] == 4'd0);
      return b;
   endfunction

   task automatic model_reset();
      pend      = 1'b0;
      k         = 0;
      acc       = 0;
      exp_dig   = '0;
      exp_blank = 4'b1110;
      exp_done  = 1'b0;
   endtask

   task automatic check_all();
      logic [12:0] exp_divin;
      exp_divin = pend ? 13'(acc / pow10[k]) : 13'd0;
      chk("busy", 16'(busy_a), 16'(pend));
      chk("done", 16'(done_a), 16'(exp_done));
      chk("divin", 16'(div_in_a), 16'(exp_divin));
      chk("digits", {d3_a, d2_a, d1_a, d0_a}, exp_dig);
      chk("blank", 16'(blank_a), 16'(exp_blank));
      chk("nb_digits", {d3_b, d2_b, d1_b, d0_b}, exp_dig);
      chk("nb_blank", 16'(blank_b), 16'd0);
      chk("nb_done", 16'(done_b), 16'(exp_done));
   endtask

   // Advance one clock with the currently driven inputs, update the model, check outputs.
   task automatic cycle();
      bit clr;
      clr = Clear;
      if (clr) begin
         pend      = 1'b0;
         exp_dig   = '0;
         exp_blank = 4'b1110;
      end else if (!pend && Start) begin
         pend = 1'b1;
         k    = -1;
         acc  = int'(Score);
      end
      @(posedge clk);
      #1;
      exp_done = 1'b0;
      if (!clr && pend) begin
         k++;
         if (k == 5) begin
            pend     = 1'b0;
            exp_done = 1'b1;
            done_seen++;
            for (int i = 0; i < 4; i++) exp_dig[i*4 +: 4] = 4'((acc / pow10[i]) % 10);
            exp_blank = blank_of(exp_dig);
         end
      end
      check_all();
   endtask

   task automatic convert(input logic [12:0] s);
      Score = s;
      Start = 1'b1;
      cycle();
      Start = 1'b0;
      Score = 13'(~s);
      repeat (6) cycle();
   endtask

   initial begin
      logic [15:0] dig;
      Score     = '0;
      Start     = 1'b0;
      Clear     = 1'b0;
      done_seen = 0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();

      // Directed conversions with known decimal results.
      convert(13'd1234);
      dig = {d3_a, d2_a, d1_a, d0_a};
      chk("d1234", dig, 16'h1234);
      convert(13'd7);
      chk("blank7", 16'(blank_a), 16'b1110);
      convert(13'd8191);
      dig = {d3_a, d2_a, d1_a, d0_a};
      chk("d8191", dig, 16'h8191);
      convert(13'd0);
      chk("blank0", 16'(blank_a), 16'b1110);

      for (int n = 0; n < 12; n++) convert(13'($urandom_range(0, 8191)));

      // Start held high with Score changing every cycle: back-to-back conversions.
      done_seen = 0;
      Start = 1'b1;
      for (int n = 0; n < 36; n++) begin
         Score = 13'($urandom_range(0, 8191));
         cycle();
      end
      Start = 1'b0;
      repeat (6) cycle();
      chk("b2b_dones", 16'(done_seen), 16'd6);

      // Random start/clear traffic.
      for (int n = 0; n < 80; n++) begin
         Score = 13'($urandom_range(0, 8191));
         Start = 1'($urandom_range(0, 1));
         Clear = ($urandom_range(0, 15) == 0);
         cycle();
      end
      Start = 1'b0;
      Clear = 1'b0;
      repeat (6) cycle();

      // Asynchronous reset after E2 of a conversion.
      convert(13'd9);
      Score = 13'd555;
      Start = 1'b1;
      cycle();
      Start = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      repeat (7) cycle();
      convert(13'd42);
      dig = {d3_a, d2_a, d1_a, d0_a};
      chk("d42", dig, 16'h0042);

      // Clear with Start in IDLE.
      Clear = 1'b1;
      Start = 1'b1;
      Score = 13'd3210;
      cycle();
      Clear = 1'b0;
      Start = 1'b0;
      repeat (6) cycle();

      // Clear while in COMMIT.
      convert(13'd77);
      Score = 13'd6543;
      Start = 1'b1;
      cycle();
      Start = 1'b0;
      repeat (4) cycle();
      Clear = 1'b1;
      cycle();
      Clear = 1'b0;
      repeat (3) cycle();
      dig = {d3_a, d2_a, d1_a, d0_a};
      chk("clr_commit_digits", dig, 16'h0000);
      chk("clr_commit_blank", 16'(blank_a), 16'b1110);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_display_sequencer.md
SCORE_DISPLAY_SEQUENCER -- requirements
Module: score_display_sequencer

Interface
REQ-001 Parameter: BLANK_LEADING, default 1, enables leading-zero blanking flags (1) or forces all Blank bits to 0 (0).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Score  input  13  unsigned binary score (0..8191) to convert.
REQ-005 Start  input  1  conversion request; sampled only in IDLE.
REQ-006 Clear  input  1  synchronous clear: abort any conversion and zero displayed digits.
REQ-007 DivIn  output  13  operand driven to the shared external divide-by-10 unit.
REQ-008 DivQuot  input  13  DivIn / 10 from the shared unit, combinational, same cycle.
REQ-009 DivRem  input  4  DivIn mod 10 from the shared unit, combinational, same cycle.
REQ-010 Digit0..Digit3  output  4 each  registered BCD digits; Digit0 = ones, Digit3 = thousands.
REQ-011 Blank  output  4  per-digit leading-zero flags, bit i for Digit i; bit 0 always 0.
REQ-012 Busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-013 Done  output  1  one-cycle pulse when new digits are committed.

Function
REQ-014 FSM states SHALL be IDLE, DIV and COMMIT; Busy SHALL be decoded from registered state only.
REQ-015 Internals: 13-bit work register Work, 2-bit digit counter Cnt, four 4-bit shadow digits Sh0..Sh3.
REQ-016 DivIn SHALL equal Work at all times, with no combinational path from Score, Start or Clear.
REQ-017 IDLE, Start=1, Clear=0 at edge E0: Work<=Score, Cnt<=0, state<=DIV; Score is not sampled at any other edge.
REQ-018 DIV at edges E1..E4: Sh[Cnt]<=DivRem, Work<=DivQuot, Cnt<=Cnt+1; at the edge where Cnt==3, state<=COMMIT.
REQ-019 COMMIT at edge E5: Digit0..3<=Sh0..Sh3, Blank updated, Done<=1, state<=IDLE.
REQ-020 Done SHALL be high only in the cycle after E5; latency Start-accept to Done-high is 5 edges.
REQ-021 Blank (BLANK_LEADING=1): Blank[3]=(D3==0); Blank[2]=Blank[3]&(D2==0); Blank[1]=Blank[2]&(D1==0); Blank[0]=0; registered with the digits.
REQ-022 Start while Busy SHALL be ignored, not queued; Start in the Done-pulse cycle is accepted (back-to-back period 6 cycles).
REQ-023 Digit and Blank outputs SHALL hold their last committed values during a conversion and change only at COMMIT, Clear or reset.
REQ-024 Clear=1 at any edge: state<=IDLE, Cnt<=0, Work<=0, Sh*<=0, digits<=0, Blank<=(BLANK_LEADING ? 4'b1110 : 0), Done<=0; Clear wins over Start and over COMMIT.
REQ-025 DivRem values are stored unmodified; the block SHALL NOT saturate or check them.
REQ-026 The thousands digit for Score<=8191 is <=8; Work after E4 is 0 and is not checked.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, Busy 0, Done 0, Work 0, Cnt 0, Sh* 0, Digit0..3 0, Blank = (BLANK_LEADING ? 4'b1110 : 4'b0000).
REQ-028 Reset asserted mid-conversion SHALL abort with no Done pulse; the first Start after rst_n rises is accepted normally.

Verification
REQ-029 Score=1234, Start 1 cycle -> DivIn 1234,123,12,1 on E1..E4; Done 1 cycle after E5; Digits 4,3,2,1; Blank 0000.
REQ-030 Score=7 -> Digits 7,0,0,0, Blank 1110; with BLANK_LEADING=0 -> Blank 0000.
REQ-031 Score=8191 -> Digits 1,9,1,8; Score=0 -> Digits 0,0,0,0, Blank 1110.
REQ-032 Start held high with Score changing each cycle -> Done every 6 cycles; each result matches Score at its accept edge; Start during Busy has no effect.
REQ-033 rst_n low during DIV (after E2) -> outputs reach reset values without waiting for a clock edge; no Done; a later conversion of 42 -> 2,4,0,0.
REQ-034 Clear and Start asserted together in IDLE, and Clear asserted in COMMIT -> no conversion starts, no Done, Digits 0, Blank 1110.
